// File: rtl/pwm_tone_detector_if.sv
// pwm_tone_detector_if: audio line in, measurement and tone status out
// Ports: audio_in (1-bit PWM line), period_out/high_out (CNT_W), meas_valid,
// tone_id (2), tone_valid, silence. slave = detector side, master = driver/observer.
interface pwm_tone_detector_if #(
    parameter int CNT_W = 18
);
    logic             audio_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic [1:0]       tone_id;
    logic             tone_valid;
    logic             silence;

    modport master (
        output audio_in,
        input  period_out, high_out, meas_valid, tone_id, tone_valid, silence
    );

    modport slave (
        input  audio_in,
        output period_out, high_out, meas_valid, tone_id, tone_valid, silence
    );
endinterface

// File: rtl/pwm_tone_detector.sv
// pwm_tone_detector: measures PWM period/high time and classifies lock-status tones
// Ports: clk (system clock), reset (async, active-low), bus (slave modport):
// audio_in in; period_out, high_out, meas_valid, tone_id, tone_valid, silence out.
module pwm_tone_detector #(
    parameter int CNT_W         = 18,
    parameter int TONE_A_PERIOD = 113636,
    parameter int TONE_B_PERIOD = 56818,
    parameter int TONE_C_PERIOD = 227272,
    parameter int TOL           = 2048,
    parameter int MATCH_COUNT   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_tone_detector_if.slave   bus
);
    localparam int SW = $clog2(MATCH_COUNT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = '1;
    localparam logic [CNT_W:0] TA = (CNT_W+1)'(TONE_A_PERIOD);
    localparam logic [CNT_W:0] TB = (CNT_W+1)'(TONE_B_PERIOD);
    localparam logic [CNT_W:0] TC = (CNT_W+1)'(TONE_C_PERIOD);
    localparam logic [CNT_W:0] TW = (CNT_W+1)'(TOL);
    localparam logic [SW-1:0]  MC = SW'(MATCH_COUNT);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt, hcnt, hlatch;
    logic [1:0]       prev_cls, cls;
    logic [SW-1:0]    streak, nstreak;
    logic             rise, fall;

    // One extra bit keeps the absolute difference from wrapping.
    function automatic logic near(input logic [CNT_W:0] p, input logic [CNT_W:0] t);
        return (p >= t ? p - t : t - p) <= TW;
    endfunction

    always_comb begin
        rise    = s2 & ~s3;
        fall    = ~s2 & s3;
        cls     = near({1'b0, cnt}, TA) ? 2'd1 :
                  near({1'b0, cnt}, TB) ? 2'd2 :
                  near({1'b0, cnt}, TC) ? 2'd3 : 2'd0;
        nstreak = cls == 2'd0      ? '0 :
                  cls != prev_cls  ? SW'(1) :
                  streak == MC     ? streak : streak + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            {s1, s2, s3}   <= '0;
            cnt            <= '0;
            hcnt           <= '0;
            hlatch         <= '0;
            prev_cls       <= '0;
            streak         <= '0;
            bus.period_out <= '0;
            bus.high_out   <= '0;
            bus.meas_valid <= 1'b0;
            bus.tone_id    <= '0;
            bus.tone_valid <= 1'b0;
            bus.silence    <= 1'b1;
        end else begin
            s1             <= bus.audio_in;
            s2             <= s1;
            s3             <= s2;
            bus.meas_valid <= 1'b0;
            if (state == IDLE) begin
                if (rise) begin
                    cnt   <= CNT_W'(1);
                    hcnt  <= CNT_W'(1);
                    state <= MEASURE;
                end
            end else if (rise) begin
                bus.period_out <= cnt;
                bus.high_out   <= hlatch;
                bus.meas_valid <= 1'b1;
                bus.silence    <= 1'b0;
                cnt            <= CNT_W'(1);
                hcnt           <= CNT_W'(1);
                prev_cls       <= cls;
                streak         <= nstreak;
                if (nstreak == MC) begin
                    bus.tone_id    <= cls;
                    bus.tone_valid <= 1'b1;
                end else if (cls != bus.tone_id) begin
                    bus.tone_id    <= '0;
                    bus.tone_valid <= 1'b0;
                end
            end else if (cnt == MAX_CNT) begin
                // Line stuck high or low: drop the tone and restart the history.
                state          <= IDLE;
                bus.silence    <= 1'b1;
                bus.tone_id    <= '0;
                bus.tone_valid <= 1'b0;
                prev_cls       <= '0;
                streak         <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
                hcnt <= hcnt + CNT_W'(s2);
                if (fall) hlatch <= hcnt;
            end
        end
    end
endmodule

// File: tb/tb_pwm_tone_detector.sv
// tb_pwm_tone_detector: randomized self-checking bench with a waveform-level reference model
module tb_pwm_tone_detector;
    localparam int W    = 10;
    localparam int TA   = 200;
    localparam int TB   = 100;
    localparam int TC   = 400;
    localparam int TOL  = 8;
    localparam int M    = 3;
    localparam int MAXC = (1 << W) - 1;

    typedef struct {
        int p;
        int h;
        int id;
        int v;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pwm_tone_detector_if #(.CNT_W(W)) bus ();

    pwm_tone_detector #(
        .CNT_W(W), .TONE_A_PERIOD(TA), .TONE_B_PERIOD(TB), .TONE_C_PERIOD(TC),
        .TOL(TOL), .MATCH_COUNT(M)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    exp_t q[$];
    int   hist[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   armed = 0;
    int   ph, pl;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cls_of(input int p);
        if ((p > TA ? p - TA : TA - p) <= TOL) return 1;
        if ((p > TB ? p - TB : TB - p) <= TOL) return 2;
        if ((p > TC ? p - TC : TC - p) <= TOL) return 3;
        return 0;
    endfunction

    // A tone is confirmed when the last M measured periods share one non-none class.
    task automatic push_exp();
        exp_t e;
        int c;
        bit ok;
        c = cls_of(ph + pl);
        hist.push_back(c);
        ok = (c != 0) && (hist.size() >= M);
        if (ok)
            for (int k = 1; k < M; k++)
                if (hist[hist.size() - 1 - k] != c) ok = 0;
        e.p  = ph + pl;
        e.h  = ph;
        e.id = ok ? c : 0;
        e.v  = ok ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic seg(input int h, input int l);
        @(negedge clk);
        if (armed) push_exp();
        armed = 1;
        ph = h;
        pl = l;
        bus.audio_in = 1'b1;
        repeat (h) @(negedge clk);
        bus.audio_in = 1'b0;
        repeat (l - 1) @(negedge clk);
    endtask

    task automatic hold(input bit lvl);
        if (lvl) begin
            @(negedge clk);
            if (armed) push_exp();
            bus.audio_in = 1'b1;
        end
        armed = 0;
        hist.delete();
        repeat (MAXC / 2) @(negedge clk);
        chk(lvl ? "hi_sil_mid" : "lo_sil_mid", bus.silence, 0);
        repeat (MAXC / 2 + 40) @(negedge clk);
        chk(lvl ? "hi_sil" : "lo_sil", bus.silence, 1);
        chk(lvl ? "hi_sil_valid" : "lo_sil_valid", bus.tone_valid, 0);
        chk(lvl ? "hi_sil_id" : "lo_sil_id", bus.tone_id, 0);
        chk(lvl ? "hi_sil_pending" : "lo_sil_pending", q.size(), 0);
        bus.audio_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.meas_valid) begin
            if (q.size() == 0) chk("unexpected_meas", 1, 0);
            else begin
                e = q.pop_front();
                chk("period", int'(bus.period_out), e.p);
                chk("high", int'(bus.high_out), e.h);
                chk("tone_id", int'(bus.tone_id), e.id);
                chk("tone_valid", int'(bus.tone_valid), e.v);
                chk("silence_meas", int'(bus.silence), 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cur, p, h;
        bus.audio_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.audio_in = i[1];
        end
        chk("rst_period", int'(bus.period_out), 0);
        chk("rst_high", int'(bus.high_out), 0);
        chk("rst_meas", int'(bus.meas_valid), 0);
        chk("rst_id", int'(bus.tone_id), 0);
        chk("rst_valid", int'(bus.tone_valid), 0);
        chk("rst_silence", int'(bus.silence), 1);
        bus.audio_in = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        repeat (5) seg(TA / 2, TA / 2);
        repeat (4) seg(TB / 2, TB / 2);
        seg(100, TA + TOL - 100);
        seg(60, TA - TOL - 60);
        seg(90, TA + TOL + 1 - 90);
        seg(75, 75);
        repeat (4) seg(TA / 2, TA / 2);

        repeat (4) seg(TC / 4, TC - TC / 4);
        hold(0);
        repeat (4) seg(TC / 4, TC - TC / 4);
        hold(1);

        repeat (4) seg(TA / 2, TA / 2);
        seg(TA / 2, 60);
        chk("pre_rst_valid", int'(bus.tone_valid), 1);
        reset = 1'b0;
        #1;
        chk("async_period", int'(bus.period_out), 0);
        chk("async_id", int'(bus.tone_id), 0);
        chk("async_valid", int'(bus.tone_valid), 0);
        chk("async_silence", int'(bus.silence), 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        armed = 0;
        hist.delete();
        repeat (30) @(negedge clk);
        repeat (5) seg(TA / 2, TA / 2);

        cur = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) cur = int'($urandom_range(0, 3));
            case (cur)
                1:       p = TA + int'($urandom_range(0, 2 * TOL)) - TOL;
                2:       p = TB + int'($urandom_range(0, 2 * TOL)) - TOL;
                3:       p = TC + int'($urandom_range(0, 2 * TOL)) - TOL;
                default: p = int'($urandom_range(20, 700));
            endcase
            h = int'($urandom_range(2, p - 2));
            seg(h, p - h);
        end
        hold(0);
        chk("final_pending", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
